memory_readback: RTL and testbench

Readback path for the UART-programmed sequencer memory space. Accepts 2-byte read commands from the UART RX byte stream, issues a single read to the BRAM banks or the register space, and serializes the returned word as UART TX bytes under a busy/strobe handshake. Sits between the UART RX demux, the memory space's read port and the UART transmitter, letting the host verify what it wrote.

---
 rtl/memory_readback_pkg.sv | 30 +++
 rtl/memory_readback_tx_seq.sv | 78 +++++++
 rtl/memory_readback.sv | 160 ++++++++++++++++
 tb/tb_memory_readback.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/memory_readback_pkg.sv
// Shared types and command/response constants for the memory readback path.
package memory_readback_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRdWait,
        StTx
    } state_e;

    typedef enum logic [1:0] {
        SeqIdle,
        SeqSend,
        SeqHold
    } seq_state_e;

    // Command byte 1 fields
    localparam int unsigned CmdRegSelBit   = 7;
    localparam int unsigned CmdBramSelMsb  = 6;
    localparam int unsigned CmdBramSelLsb  = 4;
    localparam int unsigned CmdAddrHiMsb   = 3;
    // Command byte 2 fields
    localparam int unsigned CmdAddrLoMsb   = 7;
    localparam int unsigned CmdAddrLoLsb   = 5;

    localparam int unsigned RespBytesPlain = 2;
    localparam int unsigned RespBytesEcho  = 3;
    localparam int unsigned RespBytesMax   = 3;
    localparam int unsigned RespCntW       = 2;

endpackage

// File: rtl/memory_readback_tx_seq.sv
// uart_tx_sequencer: sends a loaded list of bytes to a UART transmitter under a
// busy/strobe handshake, ignoring busy for one cycle after each strobe.
module uart_tx_sequencer
    import memory_readback_pkg::*;
#(
    parameter int unsigned MaxBytes = 3
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              load_i,
    input  logic [$clog2(MaxBytes+1)-1:0]     num_bytes_i,
    input  logic [MaxBytes-1:0][7:0]          bytes_i,
    input  logic                              tx_busy_i,
    output logic                              tx_wr_en_o,
    output logic [7:0]                        tx_data_o,
    output logic                              done_o
);

    localparam int unsigned CntW = $clog2(MaxBytes + 1);

    seq_state_e               state_q, state_d;
    logic [CntW-1:0]          idx_q, idx_d;
    logic [CntW-1:0]          num_q, num_d;
    logic [MaxBytes-1:0][7:0] bytes_q, bytes_d;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        num_d      = num_q;
        bytes_d    = bytes_q;
        tx_wr_en_o = 1'b0;
        done_o     = 1'b0;
        unique case (state_q)
            SeqIdle: begin
                if (load_i) begin
                    bytes_d = bytes_i;
                    num_d   = num_bytes_i;
                    idx_d   = '0;
                    state_d = SeqSend;
                end
            end
            SeqSend: begin
                if (!tx_busy_i) begin
                    tx_wr_en_o = 1'b1;
                    state_d    = SeqHold;
                end
            end
            SeqHold: begin
                // Transmitter raises busy one cycle after the strobe, so skip sampling it here
                if (idx_q == num_q - CntW'(1)) begin
                    done_o  = 1'b1;
                    state_d = SeqIdle;
                end else begin
                    idx_d   = idx_q + CntW'(1);
                    state_d = SeqSend;
                end
            end
            default: state_d = SeqIdle;
        endcase
    end

    assign tx_data_o = bytes_q[idx_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SeqIdle;
            idx_q   <= '0;
            num_q   <= '0;
            bytes_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            num_q   <= num_d;
            bytes_q <= bytes_d;
        end
    end

endmodule

// File: rtl/memory_readback.sv
// Two-byte UART read command -> single memory read -> serialized TX response.
// MEMORY_READBACK_ECHO_EN prefixes each response with command byte 1.
module memory_readback
    import memory_readback_pkg::*;
#(
    parameter int unsigned RD_LATENCY     = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        uart_rx_wr_en,
    input  logic [7:0]  uart_rx_data,
    output logic        rd_en,
    output logic [3:0]  rd_sel,
    output logic [6:0]  rd_addr,
    input  logic [15:0] rd_data,
    output logic        tx_wr_en,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    output logic        cmd_overrun,
    output logic        busy
);

    localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned LatW = 2;

    state_e                       state_q, state_d;
    logic                         byte_cnt_q, byte_cnt_d;
    logic [7:0]                   b1_q, b1_d;
    logic [ToW-1:0]               to_cnt_q, to_cnt_d;
    logic [LatW-1:0]              lat_cnt_q, lat_cnt_d;
    logic                         rd_en_q, rd_en_d;
    logic [3:0]                   rd_sel_q, rd_sel_d;
    logic [6:0]                   rd_addr_q, rd_addr_d;
    logic                         cmd_overrun_q, cmd_overrun_d;
    logic                         seq_load, seq_done;
    logic [7:0]                   resp_hi, resp_lo;
    logic [RespBytesMax-1:0][7:0] resp_bytes;
    logic [RespCntW-1:0]          resp_num;

    always_comb begin
        resp_lo = rd_data[7:0];
        if (rd_sel_q[3]) begin
            resp_hi = rd_data[15:8];
        end else begin
            resp_hi = {4'h0, rd_data[11:8]};
        end
    end

`ifdef MEMORY_READBACK_ECHO_EN
    assign resp_bytes = {resp_lo, resp_hi, b1_q};
    assign resp_num   = RespCntW'(RespBytesEcho);
`else
    assign resp_bytes = {8'h00, resp_lo, resp_hi};
    assign resp_num   = RespCntW'(RespBytesPlain);
`endif

    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        b1_d          = b1_q;
        to_cnt_d      = to_cnt_q;
        lat_cnt_d     = lat_cnt_q;
        rd_en_d       = 1'b0;
        rd_sel_d      = rd_sel_q;
        rd_addr_d     = rd_addr_q;
        cmd_overrun_d = uart_rx_wr_en && (state_q != StIdle);
        seq_load      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (uart_rx_wr_en) begin
                    to_cnt_d = '0;
                    if (!byte_cnt_q) begin
                        b1_d       = uart_rx_data;
                        byte_cnt_d = 1'b1;
                    end else begin
                        byte_cnt_d = 1'b0;
                        rd_en_d    = 1'b1;
                        rd_sel_d   = {b1_q[CmdRegSelBit], b1_q[CmdBramSelMsb:CmdBramSelLsb]};
                        if (b1_q[CmdRegSelBit]) begin
                            rd_addr_d = {3'b000, b1_q[CmdAddrHiMsb:0]};
                        end else begin
                            rd_addr_d = {b1_q[CmdAddrHiMsb:0],
                                         uart_rx_data[CmdAddrLoMsb:CmdAddrLoLsb]};
                        end
                        lat_cnt_d  = '0;
                        state_d    = StRdWait;
                    end
                end else if (byte_cnt_q) begin
                    // Stale partial command is dropped after the idle window
                    if (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
                        byte_cnt_d = 1'b0;
                        to_cnt_d   = '0;
                    end else begin
                        to_cnt_d = to_cnt_q + ToW'(1);
                    end
                end
            end
            StRdWait: begin
                if (lat_cnt_q == LatW'(RD_LATENCY)) begin
                    seq_load = 1'b1;
                    state_d  = StTx;
                end else begin
                    lat_cnt_d = lat_cnt_q + LatW'(1);
                end
            end
            StTx: begin
                if (seq_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            byte_cnt_q    <= 1'b0;
            b1_q          <= '0;
            to_cnt_q      <= '0;
            lat_cnt_q     <= '0;
            rd_en_q       <= 1'b0;
            rd_sel_q      <= '0;
            rd_addr_q     <= '0;
            cmd_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            b1_q          <= b1_d;
            to_cnt_q      <= to_cnt_d;
            lat_cnt_q     <= lat_cnt_d;
            rd_en_q       <= rd_en_d;
            rd_sel_q      <= rd_sel_d;
            rd_addr_q     <= rd_addr_d;
            cmd_overrun_q <= cmd_overrun_d;
        end
    end

    uart_tx_sequencer #(
        .MaxBytes (RespBytesMax)
    ) u_tx_seq (
        .clk_i       (clk),
        .rst_ni      (reset_n),
        .load_i      (seq_load),
        .num_bytes_i (resp_num),
        .bytes_i     (resp_bytes),
        .tx_busy_i   (tx_busy),
        .tx_wr_en_o  (tx_wr_en),
        .tx_data_o   (tx_data),
        .done_o      (seq_done)
    );

    assign rd_en       = rd_en_q;
    assign rd_sel      = rd_sel_q;
    assign rd_addr     = rd_addr_q;
    assign cmd_overrun = cmd_overrun_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_memory_readback.sv
// Directed bench for memory_readback with a latency-2 memory model and a
// transmitter that stays busy for three cycles after each strobe.
module tb_memory_readback;

    localparam int unsigned RdLat   = 2;
    localparam int unsigned Timeout = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        uart_rx_wr_en;
    logic [7:0]  uart_rx_data;
    logic        rd_en;
    logic [3:0]  rd_sel;
    logic [6:0]  rd_addr;
    logic [15:0] rd_data;
    logic        tx_wr_en;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        cmd_overrun;
    logic        busy;

    memory_readback #(
        .RD_LATENCY     (RdLat),
        .TIMEOUT_CYCLES (Timeout)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .uart_rx_wr_en (uart_rx_wr_en),
        .uart_rx_data  (uart_rx_data),
        .rd_en         (rd_en),
        .rd_sel        (rd_sel),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .tx_wr_en      (tx_wr_en),
        .tx_data       (tx_data),
        .tx_busy       (tx_busy),
        .cmd_overrun   (cmd_overrun),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory model: upper nibble of BRAM words is junk that must be ignored
    logic [11:0] bram [8][128];
    logic [15:0] regs [16];
    logic [15:0] pipe1;
    always @(posedge clk) begin
        if (rd_en) pipe1 <= rd_sel[3] ? regs[rd_addr[3:0]] : {4'hF, bram[rd_sel[2:0]][rd_addr]};
        rd_data <= pipe1;
    end

    logic force_busy = 1'b0;
    int   auto_cnt   = 0;
    always @(posedge clk) begin
        if (tx_wr_en) auto_cnt <= 3;
        else if (auto_cnt != 0) auto_cnt <= auto_cnt - 1;
    end
    assign tx_busy = force_busy || (auto_cnt != 0);

    int         cyc = 0;
    int         rd_cyc = 0;
    int         rden_cnt = 0;
    int         ovr_cnt = 0;
    int         last_tx_cyc = -100;
    logic [7:0] txq [$];
    int         txc [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rd_en) begin
            rd_cyc = cyc;
            rden_cnt++;
        end
        if (cmd_overrun) ovr_cnt++;
        if (tx_wr_en) begin
            check_eq("tx_gap_ge2", 32'((cyc - last_tx_cyc) >= 2), 32'd1);
            last_tx_cyc = cyc;
            txq.push_back(tx_data);
            txc.push_back(cyc);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        uart_rx_wr_en = 1'b1;
        uart_rx_data  = b;
        @(posedge clk);
        #1;
        uart_rx_wr_en = 1'b0;
    endtask

    task automatic wait_tx(input int n);
        for (int i = 0; i < 200 && txq.size() < n; i++) idle(1);
        check_eq("tx_count", 32'(txq.size()), 32'(n));
    endtask

    task automatic do_read(input logic [7:0] b1, input logic [7:0] b2, input int gap,
                           input logic [3:0] exp_sel, input logic [6:0] exp_addr,
                           input logic [7:0] hi, input logic [7:0] lo, input int hold_busy);
        logic [7:0] exp_q [$];
`ifdef MEMORY_READBACK_ECHO_EN
        exp_q.push_back(b1);
`endif
        exp_q.push_back(hi);
        exp_q.push_back(lo);
        txq.delete();
        txc.delete();
        force_busy = (hold_busy > 0);
        send_byte(b1);
        idle(gap);
        send_byte(b2);
        check_eq("rd_en", 32'(rd_en), 32'd1);
        check_eq("rd_sel", 32'(rd_sel), 32'(exp_sel));
        check_eq("rd_addr", 32'(rd_addr), 32'(exp_addr));
        check_eq("busy_rise", 32'(busy), 32'd1);
        idle(1);
        check_eq("rd_en_pulse", 32'(rd_en), 32'd0);
        if (hold_busy > 0) begin
            idle(hold_busy);
            check_eq("tx_held", 32'(txq.size()), 32'd0);
            force_busy = 1'b0;
        end
        wait_tx(exp_q.size());
        for (int i = 0; i < exp_q.size() && i < txq.size(); i++)
            check_eq($sformatf("tx_byte%0d", i), 32'(txq[i]), 32'(exp_q[i]));
        if (hold_busy == 0 && txc.size() > 0)
            check_eq("first_tx_lat", 32'(txc[0] - rd_cyc), 32'(RdLat + 1));
        for (int i = 0; i < 20 && busy; i++) idle(1);
        check_eq("busy_fall", 32'(busy), 32'd0);
    endtask

    int rd_before;

    initial begin
        for (int s = 0; s < 8; s++)
            for (int a = 0; a < 128; a++) bram[s][a] = 12'h000;
        for (int r = 0; r < 16; r++) regs[r] = 16'h0000;
        pipe1 = '0;
        // Address = {b1[3:0], b2[7:5]}: 0x34,0xA0 -> bank 3, 0x25
        bram[3][7'h25] = 12'hABC;
        bram[0][7'h01] = 12'h5A5;
        regs[1]        = 16'h1234;

        reset_n       = 1'b0;
        uart_rx_wr_en = 1'b0;
        uart_rx_data  = 8'h00;
        idle(3);
        check_eq("rst_rd_en", 32'(rd_en), 32'd0);
        check_eq("rst_rd_sel", 32'(rd_sel), 32'd0);
        check_eq("rst_rd_addr", 32'(rd_addr), 32'd0);
        check_eq("rst_tx_wr_en", 32'(tx_wr_en), 32'd0);
        check_eq("rst_tx_data", 32'(tx_data), 32'd0);
        check_eq("rst_overrun", 32'(cmd_overrun), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        idle(2);

        // BRAM read, upper data bits dropped
        do_read(8'h34, 8'hA0, 0, 4'h3, 7'h25, 8'h0A, 8'hBC, 0);
        // Register read
        do_read(8'h81, 8'h00, 0, 4'h8, 7'h01, 8'h12, 8'h34, 0);
        // Transmitter busy for 50 cycles
        do_read(8'h34, 8'hA0, 0, 4'h3, 7'h25, 8'h0A, 8'hBC, 50);
        // Byte 2 within the timeout window
        do_read(8'h34, 8'hA0, 10, 4'h3, 7'h25, 8'h0A, 8'hBC, 0);

        // Extra byte during RD_WAIT is dropped
        txq.delete();
        ovr_cnt = 0;
        send_byte(8'h81);
        send_byte(8'h00);
        send_byte(8'hFF);
`ifdef MEMORY_READBACK_ECHO_EN
        wait_tx(3);
        if (txq.size() == 3) check_eq("ovr_tx_hi", 32'(txq[1]), 32'h12);
`else
        wait_tx(2);
        if (txq.size() == 2) check_eq("ovr_tx_hi", 32'(txq[0]), 32'h12);
`endif
        idle(4);
        check_eq("overrun_pulses", 32'(ovr_cnt), 32'd1);
        do_read(8'h81, 8'h00, 0, 4'h8, 7'h01, 8'h12, 8'h34, 0);

        // Lone byte 1 times out, next pair decodes fresh
        rd_before = rden_cnt;
        txq.delete();
        send_byte(8'h13);
        idle(20);
        check_eq("timeout_no_rd", 32'(rden_cnt), 32'(rd_before));
        check_eq("timeout_no_tx", 32'(txq.size()), 32'd0);
        do_read(8'h00, 8'h20, 0, 4'h0, 7'h01, 8'h05, 8'hA5, 0);

        // Reset between response bytes
        txq.delete();
        send_byte(8'h34);
        send_byte(8'hA0);
        for (int i = 0; i < 50 && txq.size() < 1; i++) idle(1);
        check_eq("pre_rst_tx", 32'(txq.size()), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_rd_sel", 32'(rd_sel), 32'd0);
        check_eq("mid_rst_rd_addr", 32'(rd_addr), 32'd0);
        check_eq("mid_rst_tx_data", 32'(tx_data), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_tx_wr_en", 32'(tx_wr_en), 32'd0);
        idle(2);
        reset_n = 1'b1;
        idle(12);
        check_eq("post_rst_tx_count", 32'(txq.size()), 32'd1);
`ifdef MEMORY_READBACK_ECHO_EN
        if (txq.size() > 0) check_eq("post_rst_first", 32'(txq[0]), 32'h34);
`else
        if (txq.size() > 0) check_eq("post_rst_first", 32'(txq[0]), 32'h0A);
`endif
        do_read(8'h81, 8'h00, 0, 4'h8, 7'h01, 8'h12, 8'h34, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
